// File: rtl/display_share_arbiter.sv
// display_share_arbiter
//
// Shares one 8-digit seven-segment controller among N_REQ requesters.
// Ownership is handed out round-robin. A new owner keeps the display for
// at least HOLD_CYCLES cycles (DWELL) so its value stays readable. After
// that (OPEN) it keeps the display only until another requester asks for it.
// An owner that drops its request gives up the display at once, in either
// state. All outputs come straight from flops.
module display_share_arbiter #(
  parameter int          N_REQ       = 4,
  parameter int          HOLD_CYCLES = 100_000_000,
  parameter logic [31:0] IDLE_VAL    = 32'h0000_0000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [N_REQ-1:0]     req_in,
  input  logic [32*N_REQ-1:0]  val_in,
  output logic [31:0]          val_out,
  output logic [N_REQ-1:0]     grant_out,
  output logic                 grant_pulse_out,
  output logic                 dwell_done_out
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;

  // The counter value seen on the last cycle of the minimum dwell.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  // After reset, the search must begin at requester 0, so the previous
  // owner is taken to be the highest index.
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DWELL,
    ST_OPEN
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;   // current owner, or the last owner when idle
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        val_d;
  logic [N_REQ-1:0]   grant_d;
  logic               pulse_d;
  logic               done_d;

  logic [31:0]        vals [N_REQ];
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_req;
  logic               others_req;
  logic [31:0]        owner_val;
  logic               do_grant;
  logic               do_release;

  // Advances an index by step places, wrapping modulo N_REQ. N_REQ need not
  // be a power of two, so the index width cannot do the wrap on its own.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int               step);
    int sum;
    sum = int'(base) + step;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return IDX_W'(sum);
  endfunction

  // Splits the packed value bus into one 32-bit word per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      vals[i] = val_in[32*i +: 32];
    end
  end

  // Round-robin pick. The search starts just after the last owner, wraps,
  // and checks the last owner itself last. The first requester found wins.
  always_comb begin
    // NOTE: every combinational output is given a default before any branch,
    // so that no path leaves it unassigned and no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = owner_q;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!pick_valid && req_in[wrap_idx(owner_q, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(owner_q, k);
      end
    end
  end

  // Request and value as seen from the current owner.
  always_comb begin
    owner_req  = req_in[owner_q];
    owner_val  = vals[owner_q];
    others_req = |(req_in & ~grant_out);
  end

  // Next-state and next-output logic. Each state only decides whether to
  // grant, release or stay; the effects of a grant and of a release are
  // applied in one place at the end.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    val_d      = val_out;
    grant_d    = grant_out;
    pulse_d    = 1'b0;
    done_d     = dwell_done_out;
    do_grant   = 1'b0;
    do_release = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) do_grant = 1'b1;
        else            val_d    = IDLE_VAL;
      end

      ST_DWELL: begin
        // A drop by the owner takes priority over dwell expiry. Requests
        // from other requesters are ignored until the dwell is complete.
        if (!owner_req) begin
          if (pick_valid) do_grant   = 1'b1;
          else            do_release = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_OPEN;
          done_d  = 1'b1;
          val_d   = owner_val;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          val_d = owner_val;
        end
      end

      ST_OPEN: begin
        // The counter stays at CNT_LAST here. Any other requester takes
        // over on the next edge. The pick reaches the owner last, so it
        // cannot select the owner while someone else is asking.
        if (!owner_req) begin
          if (pick_valid) do_grant   = 1'b1;
          else            do_release = 1'b1;
        end else if (others_req) begin
          do_grant = 1'b1;
        end else begin
          val_d = owner_val;
        end
      end

      default: do_release = 1'b1;
    endcase

    if (do_grant) begin
      state_d = ST_DWELL;
      owner_d = pick_idx;
      cnt_d   = '0;
      val_d   = vals[pick_idx];
      grant_d = N_REQ'(1) << pick_idx;
      pulse_d = 1'b1;
      done_d  = 1'b0;
    end

    // Releasing the display clears the outputs. owner_q keeps the last owner
    // so that the next search still starts after it.
    if (do_release) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      val_d   = IDLE_VAL;
      grant_d = '0;
      done_d  = 1'b0;
    end
  end

  // State and output registers. Reset is asynchronous, so asserting it
  // during a dwell ends the ownership at once.
  always_ff @(posedge clk_in or negedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge, whatever the statement order.
    if (!rst_in) begin
      state_q         <= ST_IDLE;
      owner_q         <= IDX_LAST;
      cnt_q           <= '0;
      val_out         <= IDLE_VAL;
      grant_out       <= '0;
      grant_pulse_out <= 1'b0;
      dwell_done_out  <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      cnt_q           <= cnt_d;
      val_out         <= val_d;
      grant_out       <= grant_d;
      grant_pulse_out <= pulse_d;
      dwell_done_out  <= done_d;
    end
  end

endmodule

// File: tb/tb_display_share_arbiter.sv
// Testbench for display_share_arbiter.
// Inputs are driven on the falling clock edge. The reference model works in
// terms of an owner and the owner's age in cycles, and it queues the
// response expected after the next rising edge. A separate monitor samples
// the outputs shortly after each rising edge and compares them with the
// head of the queue.
module tb_display_share_arbiter;

  localparam int          N    = 4;
  localparam int          HOLD = 4;
  localparam logic [31:0] IDLE = 32'hE0E0_E0E0;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic [N-1:0]   req_in;
  logic [32*N-1:0] val_in;
  logic [31:0]    val_out;
  logic [N-1:0]   grant_out;
  logic           grant_pulse_out;
  logic           dwell_done_out;

  display_share_arbiter #(
    .N_REQ       (N),
    .HOLD_CYCLES (HOLD),
    .IDLE_VAL    (IDLE)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .req_in          (req_in),
    .val_in          (val_in),
    .val_out         (val_out),
    .grant_out       (grant_out),
    .grant_pulse_out (grant_pulse_out),
    .dwell_done_out  (dwell_done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0]  val;
    logic [N-1:0] grant;
    logic         pulse;
    logic         done;
  } exp_t;

  exp_t        sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  bit          mon_en  = 1'b1;
  logic [31:0] vals [N];

  // Reference model state: the owner index (-1 when idle), the last owner,
  // and the number of edges since the current grant.
  int          m_owner;
  int          m_last;
  int          m_age;
  logic        m_pulse;
  logic [31:0] m_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int model_pick(input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_age   = 0;
    m_pulse = 1'b0;
    m_val   = IDLE;
  endtask

  task automatic model_grant(input int p);
    m_owner = p;
    m_last  = p;
    m_age   = 0;
    m_pulse = 1'b1;
    m_val   = vals[p];
  endtask

  // Applies one clock edge to the model and queues the expected outputs.
  task automatic model_step(input logic [N-1:0] req);
    int   p;
    bit   open_pre;
    exp_t e;
    p        = model_pick(req);
    open_pre = (m_owner >= 0) && (m_age >= HOLD);
    m_pulse  = 1'b0;
    if (m_owner < 0) begin
      if (p >= 0) model_grant(p);
      else        m_val = IDLE;
    end else if (!req[m_owner]) begin
      if (p >= 0) model_grant(p);
      else begin
        m_owner = -1;
        m_val   = IDLE;
      end
    end else if (open_pre && ((req & ~(N'(1) << m_owner)) != '0)) begin
      model_grant(p);
    end else begin
      if (m_age < HOLD) m_age++;
      m_val = vals[m_owner];
    end
    e.val   = m_val;
    e.grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e.pulse = m_pulse;
    e.done  = (m_owner >= 0) && (m_age >= HOLD);
    sb.push_back(e);
  endtask

  // Call on a falling edge. Drives the inputs for the next rising edge,
  // queues the expected response, and returns on the next falling edge.
  task automatic cycle(input logic [N-1:0] req);
    req_in = req;
    for (int i = 0; i < N; i++) val_in[32*i +: 32] = vals[i];
    model_step(req);
    @(negedge clk_in);
  endtask

  task automatic randomize_vals();
    for (int i = 0; i < N; i++) vals[i] = $urandom;
  endtask

  task automatic reset_checks();
    check("rst_val_out",   val_out,                32'(IDLE));
    check("rst_grant_out", 32'(grant_out),         32'd0);
    check("rst_pulse",     32'(grant_pulse_out),   32'd0);
    check("rst_dwell",     32'(dwell_done_out),    32'd0);
  endtask

  // Scoreboard monitor: compares the outputs after each rising edge taken
  // out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (mon_en && rst_in === 1'b1) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_empty: got no expected entry, required one at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("val_out",         val_out,              e.val);
          check("grant_out",       32'(grant_out),       32'(e.grant));
          check("grant_pulse_out", 32'(grant_pulse_out), 32'(e.pulse));
          check("dwell_done_out",  32'(dwell_done_out),  32'(e.done));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    rst_in = 1'b0;
    req_in = '0;
    val_in = '0;
    for (int i = 0; i < N; i++) vals[i] = 32'h0;
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    reset_checks();
    rst_in = 1'b1;

    // Single requester: grant, full dwell, OPEN, then release.
    vals[0] = 32'h1234_5678;
    repeat (8) cycle(4'b0001);
    repeat (2) cycle(4'b0000);

    // Two requesters held together alternate after each dwell.
    randomize_vals();
    repeat (16) cycle(4'b1010);
    repeat (2) cycle(4'b0000);

    // Another request arriving during the dwell waits for OPEN.
    randomize_vals();
    cycle(4'b0001);
    repeat (8) cycle(4'b0011);
    repeat (2) cycle(4'b0000);

    // Owner drops its request partway through the dwell.
    randomize_vals();
    repeat (3) cycle(4'b0100);
    repeat (2) cycle(4'b0000);

    // Sole owner in OPEN with a value that changes every cycle.
    repeat (12) begin
      vals[0] = $urandom;
      cycle(4'b0001);
    end
    cycle(4'b0000);

    // Asynchronous reset between edges during a dwell.
    randomize_vals();
    repeat (2) cycle(4'b0010);
    #2 rst_in = 1'b0;
    #1 reset_checks();
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (10) begin
      randomize_vals();
      cycle(4'b1111);
    end

    // Random request patterns that persist over several cycles.
    r = '0;
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      randomize_vals();
      cycle(r);
    end
    cycle(4'b0000);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk_in);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL sb_drain: got %0d entries left, required 0", sb.size());
    end
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
